count_result_framer: RTL and testbench

- Sits directly downstream of the windowed pulse counter.
- Captures each window result (pulse_count, pileup_count) on count_valid and tags it with a window sequence number.
- Buffers results in a small FIFO and streams each one out as a 3-word frame on a valid/ready interface toward the readout/DMA path.
- Drops results when the FIFO is full, counts drops, and flags the next stored frame.

---
 rtl/count_frame_pkg.sv | 29 ++
 rtl/result_fifo.sv | 62 ++++++
 rtl/count_result_framer.sv | 149 ++++++++++++++
 tb/tb_count_result_framer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/count_frame_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | count_frame_pkg: frame layout constants and output FSM encoding   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package count_frame_pkg;

    localparam logic [7:0] FRAME_MAGIC   = 8'hC5;
    localparam int         FRAME_WORDS   = 3;
    localparam int         HDR_MAGIC_LSB = 24;
    localparam int         HDR_DROP_BIT  = 16;
    localparam int         HDR_SEQ_LSB   = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HDR   = 2'd1;
    localparam logic [1:0] ST_PCNT  = 2'd2;
    localparam logic [1:0] ST_PUCNT = 2'd3;

    function automatic logic [31:0] make_header(input logic drop_flag, input logic [15:0] seq);
        logic [31:0] w;
        w = '0;
        w[HDR_MAGIC_LSB +: 8] = FRAME_MAGIC;
        w[HDR_DROP_BIT]       = drop_flag;
        w[HDR_SEQ_LSB +: 16]  = seq;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | result_fifo: single-clock FIFO with head and head+1 read ports    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module result_fifo #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [WIDTH-1:0]         rnext_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             w_push;
    logic             w_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign w_pop   = pop_i && !empty_o;
    assign w_push  = push_i && (!full_o || w_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign rnext_o = mem_q[rd_ptr_q + AW'(1)];
    assign level_o = level_q;

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({w_push, w_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/count_result_framer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | count_result_framer: tags window results with a sequence number,  |
// | buffers them and streams 3-word frames.  Rev 1.0                  |
// +------------------------------------------------------------------+
module count_result_framer
    import count_frame_pkg::*;
#(
    parameter int COUNTER_WIDTH = 16,
    parameter int FIFO_DEPTH    = 8,
    parameter int SEQ_WIDTH     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          count_valid,
    input  logic [COUNTER_WIDTH-1:0]      pulse_count,
    input  logic [COUNTER_WIDTH-1:0]      pileup_count,
    input  logic                          window_active,
    output logic [31:0]                   m_data,
    output logic                          m_valid,
    output logic                          m_last,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   drop_count
);
    localparam int LW       = $clog2(FIFO_DEPTH) + 1;
    localparam int EW       = 1 + SEQ_WIDTH + 2*COUNTER_WIDTH;
    localparam int PU_LSB   = 0;
    localparam int PC_LSB   = COUNTER_WIDTH;
    localparam int SEQ_LSB  = 2*COUNTER_WIDTH;
    localparam int DROP_BIT = EW - 1;

    logic                 win_q;
    logic [SEQ_WIDTH-1:0] seq_q, seq_d;
    logic                 drop_pending_q, drop_pending_d;
    logic [15:0]          drop_count_q, drop_count_d;
    logic [1:0]           state_q, state_d;
    logic [31:0]          m_data_q, m_data_d;
    logic                 m_valid_q, m_valid_d;
    logic                 m_last_q, m_last_d;

    logic                 w_win_rise;
    logic [SEQ_WIDTH-1:0] w_seq_cur;
    logic                 w_hs, w_push, w_pop, w_full, w_empty, w_more;
    logic [EW-1:0]        w_wentry, w_rdata, w_rnext, w_next_src;
    logic [LW-1:0]        w_level;

    result_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i (w_wentry),
        .rdata_o (w_rdata),
        .rnext_o (w_rnext),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (w_level)
    );

    always_comb begin
        w_win_rise = window_active && !win_q;
        w_seq_cur  = w_win_rise ? '0 : seq_q;
        w_hs       = m_valid_q && m_ready;
        w_pop      = (state_q == ST_PUCNT) && w_hs;
        w_push     = count_valid && (!w_full || w_pop);
        w_wentry   = {drop_pending_q, w_seq_cur, pulse_count, pileup_count};
        // Next header after a pop: head+1 if queued, else the entry being written now.
        w_more     = (w_level > LW'(1)) || w_push;
        w_next_src = (w_level > LW'(1)) ? w_rnext : w_wentry;

        seq_d = seq_q;
        if (count_valid)     seq_d = w_seq_cur + SEQ_WIDTH'(1);
        else if (w_win_rise) seq_d = '0;

        drop_pending_d = drop_pending_q;
        drop_count_d   = drop_count_q;
        if (w_push) begin
            drop_pending_d = 1'b0;
        end else if (count_valid) begin
            drop_pending_d = 1'b1;
            if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
        end

        state_d   = state_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        case (state_q)
            ST_IDLE: if (!w_empty) begin
                m_data_d  = make_header(w_rdata[DROP_BIT], 16'(w_rdata[SEQ_LSB +: SEQ_WIDTH]));
                m_valid_d = 1'b1;
                m_last_d  = 1'b0;
                state_d   = ST_HDR;
            end
            ST_HDR: if (w_hs) begin
                m_data_d = 32'(w_rdata[PC_LSB +: COUNTER_WIDTH]);
                state_d  = ST_PCNT;
            end
            ST_PCNT: if (w_hs) begin
                m_data_d = 32'(w_rdata[PU_LSB +: COUNTER_WIDTH]);
                m_last_d = 1'b1;
                state_d  = ST_PUCNT;
            end
            ST_PUCNT: if (w_hs) begin
                m_last_d = 1'b0;
                if (w_more) begin
                    m_data_d = make_header(w_next_src[DROP_BIT],
                                           16'(w_next_src[SEQ_LSB +: SEQ_WIDTH]));
                    state_d  = ST_HDR;
                end else begin
                    m_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q          <= 1'b0;
            seq_q          <= '0;
            drop_pending_q <= 1'b0;
            drop_count_q   <= '0;
            state_q        <= ST_IDLE;
            m_data_q       <= '0;
            m_valid_q      <= 1'b0;
            m_last_q       <= 1'b0;
        end else begin
            win_q          <= window_active;
            seq_q          <= seq_d;
            drop_pending_q <= drop_pending_d;
            drop_count_q   <= drop_count_d;
            state_q        <= state_d;
            m_data_q       <= m_data_d;
            m_valid_q      <= m_valid_d;
            m_last_q       <= m_last_d;
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign fifo_level = w_level;
    assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_count_result_framer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_count_result_framer: directed + random bench with frame model  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_count_result_framer;
    import count_frame_pkg::*;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        count_valid = 1'b0;
    logic [15:0] pulse_count = '0;
    logic [15:0] pileup_count = '0;
    logic        window_active = 1'b0;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic [2:0]  fifo_level;
    logic [15:0] drop_count;

    count_result_framer #(.COUNTER_WIDTH(16), .FIFO_DEPTH(D), .SEQ_WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .count_valid   (count_valid),
        .pulse_count   (pulse_count),
        .pileup_count  (pileup_count),
        .window_active (window_active),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_last        (m_last),
        .m_ready       (m_ready),
        .fifo_level    (fifo_level),
        .drop_count    (drop_count)
    );

    always #6 clk = ~clk;

    // Reference model: queue of expected output words plus stored-entry count.
    logic [31:0] expq[$];
    int          occ = 0;
    int          seq_m = 0;
    int          drops_m = 0;
    bit          pend_m = 1'b0;
    bit          wa_prev = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit          hs, popev, pushed, rise;
        int          remaining, widx, sc;
        logic [31:0] pv_data;
        logic        pv_valid, pv_last;
        pv_valid = m_valid;
        pv_data  = m_data;
        pv_last  = m_last;
        hs       = m_valid && m_ready;
        popev    = 1'b0;
        if (hs) begin
            if (expq.size() == 0) begin
                chk("word_without_frame", 32'(expq.size()), 32'd1);
            end else begin
                widx = (FRAME_WORDS - expq.size() % FRAME_WORDS) % FRAME_WORDS;
                chk("word", m_data, expq[0]);
                chk("m_last", 32'(m_last), 32'(widx == FRAME_WORDS - 1));
                popev = (widx == FRAME_WORDS - 1);
                void'(expq.pop_front());
            end
        end
        remaining = expq.size();
        rise      = window_active && !wa_prev;
        sc        = rise ? 0 : seq_m;
        pushed    = 1'b0;
        if (count_valid) begin
            if (occ < D || popev) begin
                pushed = 1'b1;
                expq.push_back({FRAME_MAGIC, 7'b0, pend_m, sc[15:0]});
                expq.push_back({16'h0, pulse_count});
                expq.push_back({16'h0, pileup_count});
                pend_m = 1'b0;
            end else begin
                pend_m = 1'b1;
                if (drops_m < 65535) drops_m++;
            end
            seq_m = (sc + 1) % 65536;
        end else if (rise) begin
            seq_m = 0;
        end
        occ     = occ + int'(pushed) - int'(popev);
        wa_prev = window_active;
        @(posedge clk);
        #1;
        chk("fifo_level", 32'(fifo_level), 32'(occ));
        chk("drop_count", 32'(drop_count), 32'(drops_m));
        chk("m_valid", 32'(m_valid), 32'((remaining > 0) || (popev && pushed)));
        if (pv_valid && !hs) begin
            chk("hold_data", m_data, pv_data);
            chk("hold_last", 32'(m_last), 32'(pv_last));
        end
    endtask

    task automatic do_reset();
        count_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        expq.delete();
        occ = 0; seq_m = 0; drops_m = 0; pend_m = 1'b0; wa_prev = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic strobe(input logic [15:0] pc, input logic [15:0] pu);
        count_valid = 1'b1; pulse_count = pc; pileup_count = pu;
        cycle();
        count_valid = 1'b0;
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int i = 0; i < 200 && (expq.size() > 0 || m_valid); i++) cycle();
        chk("drain_empty", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();

        // Single result with exact latency
        window_active = 1'b1; m_ready = 1'b1;
        strobe(16'h0123, 16'h0004);
        cycle();
        chk("lat_w0", m_data, 32'hC500_0000);
        cycle();
        chk("lat_w1", m_data, 32'h0000_0123);
        chk("lat_w1_last", 32'(m_last), 32'd0);
        cycle();
        chk("lat_w2", m_data, 32'h0000_0004);
        chk("lat_w2_last", 32'(m_last), 32'd1);
        cycle();

        // Backpressure on word1
        strobe(16'hBEEF, 16'h0042);
        cycle();
        cycle();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("bp_w1", m_data, 32'h0000_BEEF);
        drain();

        // Overflow with depth 4
        do_reset();
        m_ready = 1'b0; window_active = 1'b1;
        for (int i = 0; i < 6; i++) strobe(16'(i + 16'h100), 16'(i + 16'h200));
        chk("ovf_level", 32'(fifo_level), 32'd4);
        chk("ovf_drops", 32'(drop_count), 32'd2);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        strobe(16'h0777, 16'h0007);
        drain();

        // Push coinciding with pop while full
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) strobe(16'(16'h300 + i), 16'(16'h400 + i));
        cycle();
        m_ready = 1'b1;
        cycle();
        cycle();
        chk("pwp_align", 32'(m_last), 32'd1);
        strobe(16'h0ABC, 16'h0DEF);
        chk("pwp_level", 32'(fifo_level), 32'd4);
        chk("pwp_drops", 32'(drop_count), 32'd2);
        drain();

        // Sequence restart on a window_active rising edge
        window_active = 1'b0;
        cycle();
        window_active = 1'b1;
        strobe(16'h0011, 16'h0022);
        cycle();
        chk("restart_hdr", m_data, 32'hC500_0000);
        drain();
        strobe(16'h0033, 16'h0044);
        drain();

        // Reset mid-frame
        m_ready = 1'b0;
        strobe(16'h0501, 16'h0601);
        strobe(16'h0502, 16'h0602);
        m_ready = 1'b1;
        cycle();
        do_reset();
        strobe(16'h0999, 16'h0888);
        cycle();
        chk("post_rst_hdr", m_data, 32'hC500_0000);
        drain();

        // Randomised traffic with periodic stalls
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) window_active = ~window_active;
            m_ready      = ((i / 40) % 3 == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            count_valid  = ($urandom_range(0, 3) == 0);
            pulse_count  = 16'($urandom);
            pileup_count = 16'($urandom);
            cycle();
        end
        count_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
